level_sequencer: RTL
====================

Name: level_sequencer

Overview:
- Game-flow initiator that drives the level controller's level-advance handshake.
- Runs the per-level countdown and accumulates score, then compares score against the level target at timeout.
- On a pass it shows a win banner and issues a one-cycle `cycleLevel` pulse to advance the level. On a fail it ends the game.
- Sits between the gameplay datapath (hook/score logic, 1 Hz tick) and the level controller / screen-overlay drawers.

Parameters:
- NUM_LEVELS, 4: number of levels; level index runs 0..NUM_LEVELS-1.
- LEVEL_TIME, 60: seconds per level; 7-bit timer.
- BANNER_SEC, 3: seconds the win banner is held before advancing.
- TARGET_BASE, 100: score target for level 0.
- TARGET_STEP, 150: target increment per level.
- SCORE_W, 12: score and target width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startGame  in  1  one-cycle pulse from key debouncer; starts or restarts the game.
- oneSecPulse  in  1  one-cycle 1 Hz tick.
- scoreAddValid  in  1  qualifies scoreAdd.
- scoreAdd  in  8  points from a retrieved object.
- hookBusy  in  1  hook is extending or retracting; level end is deferred while high.
- lastLevelEnded  in  1  from level controller; high once the final level has been cycled past.
- cycleLevel  out  1  one-cycle advance pulse to level controller.
- levelIndex  out  2  current level number.
- timeLeft  out  7  seconds remaining.
- score  out  SCORE_W  cumulative score.
- target  out  SCORE_W  current level target.
- enable  out  1  gameplay enabled; high only in PLAY.
- showWin  out  1  level-cleared banner.
- gameOver  out  1  lose screen.
- gameWon  out  1  final victory screen.

Behaviour:
- Ports and reset:
  - Clock is `clk`; reset is `reset`, synchronous and active-high.
  - All state is registered. Reset takes priority over every other input, including in the middle of a level or banner.
- Reset values:
  - state = IDLE, levelIndex = 0, timeLeft = LEVEL_TIME, score = 0, target = TARGET_BASE, banner counter = 0.
  - All 1-bit outputs = 0.
- States: IDLE, PLAY, WIN_BANNER, ADVANCE, LOSE, DONE.
- IDLE:
  - enable = 0.
  - On startGame: score = 0, levelIndex = 0, target = TARGET_BASE, timeLeft = LEVEL_TIME; go to PLAY on the next cycle.
- PLAY:
  - enable = 1.
  - scoreAddValid adds scoreAdd to score, saturating at 2^SCORE_W-1.
  - oneSecPulse decrements timeLeft; timeLeft holds at 0 and never wraps.
  - Once timeLeft == 0 and hookBusy == 0, the level ends that cycle. The decision uses the post-add score (an add in the decision cycle counts):
    - score >= target: go to WIN_BANNER.
    - score < target: go to LOSE.
  - While hookBusy is high at timeLeft == 0, stay in PLAY; scoring is still accepted.
  - startGame is ignored in PLAY.
- WIN_BANNER:
  - showWin = 1, enable = 0.
  - The banner counter increments on each oneSecPulse.
  - When the count reaches BANNER_SEC:
    - If levelIndex == NUM_LEVELS-1 or lastLevelEnded == 1: go to DONE.
    - Otherwise: go to ADVANCE.
  - The counter is cleared on exit.
- ADVANCE (exactly one cycle):
  - cycleLevel = 1, levelIndex += 1, target += TARGET_STEP (saturating), timeLeft = LEVEL_TIME.
  - score is retained. Go to PLAY.
  - oneSecPulse in this cycle is ignored.
- LOSE: gameOver = 1 held; startGame performs the IDLE start sequence directly into PLAY.
- DONE: gameWon = 1 held; startGame restarts the same way as from LOSE.
- Output rules:
  - cycleLevel is never high for more than one consecutive cycle.
  - cycleLevel is never asserted outside ADVANCE.
  - showWin, gameOver and gameWon are mutually exclusive.
- Timing: all outputs are registered, so they follow the state with 1-cycle latency from the inputs.

Test Plan:
1. Reset, startGame, 60 oneSecPulse, scoreAdd totals 120, hookBusy = 0 → timeLeft reaches 0; next cycle WIN_BANNER with showWin = 1. After 3 pulses, cycleLevel high for exactly 1 cycle; then levelIndex = 1, target = 250, timeLeft = 60, score = 120.
2. Level 0 with score 99 at timeout → gameOver = 1, cycleLevel never asserted. startGame → score = 0, levelIndex = 0, enable = 1.
3. timeLeft = 0 while hookBusy = 1 for 20 cycles with a scoreAdd of 5 in that window (score 95 → 100) → stays in PLAY; on hookBusy fall, goes to WIN_BANNER (100 >= 100).
4. Clear all 4 levels → after the level-3 banner, gameWon = 1, exactly 3 cycleLevel pulses total. A separate run forces lastLevelEnded = 1 during the level-1 banner → DONE.
5. scoreAdd = 255 every cycle from score 4000 → score saturates at 4095, no wrap. scoreAddValid in the exact decision cycle is included in the compare.
6. reset asserted mid-WIN_BANNER and mid-ADVANCE → next cycle all outputs at reset values, cycleLevel = 0.

Source files
------------

// File: rtl/level_sequencer.sv
// Game-flow sequencer: per-level countdown, score accumulation, and the pass/fail decision at
// timeout. It also runs the win banner and sends the one-cycle level-advance pulse.
module level_sequencer #(
  parameter int NUM_LEVELS  = 4,
  parameter int LEVEL_TIME  = 60,
  parameter int BANNER_SEC  = 3,
  parameter int TARGET_BASE = 100,
  parameter int TARGET_STEP = 150,
  parameter int SCORE_W     = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startGame,
  input  logic               oneSecPulse,
  input  logic               scoreAddValid,
  input  logic [7:0]         scoreAdd,
  input  logic               hookBusy,
  input  logic               lastLevelEnded,
  output logic               cycleLevel,
  output logic [1:0]         levelIndex,
  output logic [6:0]         timeLeft,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] target,
  output logic               enable,
  output logic               showWin,
  output logic               gameOver,
  output logic               gameWon
);

  localparam int BW = $clog2(BANNER_SEC + 1);
  localparam logic [1:0]         LAST_LEVEL  = 2'(NUM_LEVELS - 1);
  localparam logic [6:0]         LEVEL_TIME_C = 7'(LEVEL_TIME);
  localparam logic [BW-1:0]      BANNER_C    = BW'(BANNER_SEC);
  localparam logic [SCORE_W-1:0] TBASE_C     = SCORE_W'(TARGET_BASE);
  localparam logic [SCORE_W:0]   TSTEP_C     = (SCORE_W+1)'(TARGET_STEP);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    WIN_BANNER = 3'd2,
    ADVANCE    = 3'd3,
    LOSE       = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         level_q, level_d;
  logic [6:0]         time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] target_q, target_d;
  logic [BW-1:0]      banner_q, banner_d;
  logic               cycle_q, cycle_d;
  logic               enable_q, enable_d;
  logic               win_q, win_d;
  logic               over_q, over_d;
  logic               won_q, won_d;

  logic [SCORE_W:0]   score_sum_s;
  logic [SCORE_W:0]   target_sum_s;
  logic [SCORE_W-1:0] score_sat_s;
  logic [SCORE_W-1:0] target_sat_s;
  logic [BW-1:0]      banner_inc_s;

  // Saturating adders for score and target.
  always_comb begin
    score_sum_s  = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(scoreAdd);
    target_sum_s = (SCORE_W+1)'(target_q) + TSTEP_C;
    banner_inc_s = banner_q + BW'(1);
    if (score_sum_s[SCORE_W]) begin
      score_sat_s = '1;
    end else begin
      score_sat_s = score_sum_s[SCORE_W-1:0];
    end
    if (target_sum_s[SCORE_W]) begin
      target_sat_s = '1;
    end else begin
      target_sat_s = target_sum_s[SCORE_W-1:0];
    end
  end

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    time_d   = time_q;
    score_d  = score_q;
    target_d = target_q;
    banner_d = banner_q;
    case (state_q)
      IDLE, LOSE, DONE: begin
        if (startGame) begin
          score_d  = '0;
          level_d  = 2'd0;
          target_d = TBASE_C;
          time_d   = LEVEL_TIME_C;
          banner_d = '0;
          state_d  = PLAY;
        end else begin
          state_d  = state_q;
        end
      end
      PLAY: begin
        if (scoreAddValid) begin
          score_d = score_sat_s;
        end else begin
          score_d = score_q;
        end
        if (oneSecPulse && (time_q != 7'd0)) begin
          time_d = time_q - 7'd1;
        end else begin
          time_d = time_q;
        end
        // The decision sees this cycle's add, but only the registered timer value.
        if ((time_q == 7'd0) && !hookBusy) begin
          if (score_d >= target_q) begin
            state_d = WIN_BANNER;
          end else begin
            state_d = LOSE;
          end
        end else begin
          state_d = PLAY;
        end
      end
      WIN_BANNER: begin
        if (oneSecPulse) begin
          if (banner_inc_s == BANNER_C) begin
            banner_d = '0;
            if ((level_q == LAST_LEVEL) || lastLevelEnded) begin
              state_d = DONE;
            end else begin
              state_d = ADVANCE;
            end
          end else begin
            banner_d = banner_inc_s;
          end
        end else begin
          banner_d = banner_q;
        end
      end
      ADVANCE: begin
        level_d  = level_q + 2'd1;
        target_d = target_sat_s;
        time_d   = LEVEL_TIME_C;
        state_d  = PLAY;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    enable_d = (state_d == PLAY);
    win_d    = (state_d == WIN_BANNER);
    cycle_d  = (state_d == ADVANCE);
    over_d   = (state_d == LOSE);
    won_d    = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= 2'd0;
      time_q   <= LEVEL_TIME_C;
      score_q  <= '0;
      target_q <= TBASE_C;
      banner_q <= '0;
      cycle_q  <= 1'b0;
      enable_q <= 1'b0;
      win_q    <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      time_q   <= time_d;
      score_q  <= score_d;
      target_q <= target_d;
      banner_q <= banner_d;
      cycle_q  <= cycle_d;
      enable_q <= enable_d;
      win_q    <= win_d;
      over_q   <= over_d;
      won_q    <= won_d;
    end
  end

  assign cycleLevel = cycle_q;
  assign levelIndex = level_q;
  assign timeLeft   = time_q;
  assign score      = score_q;
  assign target     = target_q;
  assign enable     = enable_q;
  assign showWin    = win_q;
  assign gameOver   = over_q;
  assign gameWon    = won_q;

endmodule
